// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with selectable FWFT read mode, fill level,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Optional feature macro: SYNC_FIFO_PARITY_EN (per-entry parity bit, rd_par_err).
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int FIFO_AEMPTY = 1,
    parameter int FWFT        = 0,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  rd_par_err
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0] DEPTH_LV  = FIFO_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_LV  = FIFO_AFULL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_LV = FIFO_AEMPTY[ADDR_WIDTH:0];

    logic [MEM_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                  wr_acc, rd_acc;
    logic [MEM_WIDTH-1:0]  wr_word, head_word;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_perr;

    // Accept decisions, next pointers and next fill level from registered flags
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Storage word formation and head-of-queue decode
    always_comb begin
`ifdef SYNC_FIFO_PARITY_EN
        wr_word   = {^wr_data, wr_data};
        head_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
        head_data = head_word[DATA_WIDTH-1:0];
        head_perr = (^head_data) != head_word[DATA_WIDTH];
`else
        wr_word   = wr_data;
        head_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
        head_data = head_word;
        head_perr = 1'b0;
`endif
    end

    // Storage array write port; contents intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    // Pointers, status flags and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            full      <= (count_nxt == DEPTH_LV);
            empty     <= (count_nxt == '0);
            afull     <= (count_nxt >= AFULL_LV);
            aempty    <= (count_nxt <= AEMPTY_LV);
            // set event in the same cycle as err_clr keeps the flag high
            overflow  <= (overflow  & ~err_clr) | (wr_en & full);
            underflow <= (underflow & ~err_clr) | (rd_en & empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word presented combinationally; gated to zero while empty
            always_comb begin
                rd_valid   = ~empty;
                rd_data    = empty ? '0 : head_data;
                rd_par_err = head_perr & ~empty;
            end
        end else begin : g_std
            logic perr_q;

            // Registered read: data and its parity check captured on accept
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                    perr_q   <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= head_data;
                        perr_q  <= head_perr;
                    end
                end
            end

            // Parity error only reported alongside valid read data
            always_comb begin
                rd_par_err = perr_q & rd_valid;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: drives a standard-read and an FWFT instance with the same
// stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = '0;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [4:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_udf, f_udf, s_perr, f_perr;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // reference model: entries hold data in [7:0], corrupted-parity marker in bit 8
    int   q[$];
    bit   m_ovf, m_udf, m_s_valid, m_s_perr;
    int   m_s_data;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .afull(s_afull), .aempty(s_aempty), .count(s_count), .err_clr(err_clr),
        .overflow(s_ovf), .underflow(s_udf), .rd_par_err(s_perr)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .afull(f_afull), .aempty(f_aempty), .count(f_count), .err_clr(err_clr),
        .overflow(f_ovf), .underflow(f_udf), .rd_par_err(f_perr)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check_val("s_count",  32'(s_count),  32'(n));
        check_val("f_count",  32'(f_count),  32'(n));
        check_val("s_full",   32'(s_full),   32'(n == 16));
        check_val("f_full",   32'(f_full),   32'(n == 16));
        check_val("s_empty",  32'(s_empty),  32'(n == 0));
        check_val("f_empty",  32'(f_empty),  32'(n == 0));
        check_val("s_afull",  32'(s_afull),  32'(n >= 15));
        check_val("f_afull",  32'(f_afull),  32'(n >= 15));
        check_val("s_aempty", 32'(s_aempty), 32'(n <= 1));
        check_val("f_aempty", 32'(f_aempty), 32'(n <= 1));
        check_val("s_ovf",    32'(s_ovf),    32'(m_ovf));
        check_val("f_ovf",    32'(f_ovf),    32'(m_ovf));
        check_val("s_udf",    32'(s_udf),    32'(m_udf));
        check_val("f_udf",    32'(f_udf),    32'(m_udf));
        check_val("s_rd_valid", 32'(s_rd_valid), 32'(m_s_valid));
        check_val("s_rd_data",  32'(s_rd_data),  32'(m_s_data));
        check_val("s_perr",     32'(s_perr),     32'(m_s_perr & m_s_valid));
        check_val("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) begin
            check_val("f_rd_data", 32'(f_rd_data), 32'(q[0] & 8'hFF));
            check_val("f_perr",    32'(f_perr),    32'((q[0] >> 8) & 1));
        end else begin
            check_val("f_perr_empty", 32'(f_perr), 32'(0));
        end
    endtask

    task automatic model_step(input bit w, input bit r, input int d, input bit c);
        int  n;
        bit  was_full, was_empty;
        n         = q.size();
        was_full  = (n == 16);
        was_empty = (n == 0);
        m_s_valid = r && !was_empty;
        if (r && !was_empty) begin
            m_s_data = q[0] & 8'hFF;
            m_s_perr = ((q[0] >> 8) & 1) != 0;
            void'(q.pop_front());
        end
        if (w && !was_full) q.push_back(d & 8'hFF);
        m_ovf = (m_ovf && !c) || (w && was_full);
        m_udf = (m_udf && !c) || (r && was_empty);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_s_valid = 0; m_s_perr = 0; m_s_data = 0;
    endtask

    // one clock: check state at negedge, drive inputs, advance model at posedge
    task automatic cycle(input bit w, input bit r, input int d, input bit c);
        @(negedge clk);
        check_all();
        wr_en   = w;
        rd_en   = r;
        wr_data = d[7:0];
        err_clr = c;
        @(posedge clk);
        model_step(w, r, d, c);
    endtask

    // asynchronous reset asserted mid-cycle, observed before any clock edge
    task automatic do_reset();
        @(negedge clk);
        wr_en = 0; rd_en = 0; err_clr = 0;
        rst = 1;
        #1;
        model_reset();
        check_val("rst_count",  32'(s_count),    32'(0));
        check_val("rst_empty",  32'(s_empty),    32'(1));
        check_val("rst_valid",  32'(s_rd_valid), 32'(0));
        check_val("rst_fvalid", 32'(f_rd_valid), 32'(0));
        check_val("rst_data",   32'(s_rd_data),  32'(0));
        check_all();
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // fill to full, one dropped write, then clear overflow
        for (int i = 0; i < 17; i++) cycle(1, 0, i, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // drain, then read while empty
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);

        // simultaneous traffic at mid level, full and empty
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'h40 + i, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 8'h80 + i, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'h90 + i, 0);
        cycle(1, 1, 8'hEE, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);
        cycle(1, 1, 8'h5A, 0);
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 0);

        // single word fall-through
        cycle(1, 0, 8'hA5, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 400; i++) begin
            bit hi;
            hi = ((i / 40) % 2) == 0;
            cycle($urandom_range(0, 99) < (hi ? 75 : 30),
                  $urandom_range(0, 99) < (hi ? 30 : 75),
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 19) == 0);
        end

        // reset in the middle of operation with five words stored
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'hC0 + i, 0);
        cycle(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'h20 + i, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

`ifdef SYNC_FIFO_PARITY_EN
        // corrupt the stored parity of word 0x3C in both instances
        do_reset();
        cycle(1, 0, 8'h3C, 0);
        cycle(1, 0, 8'h11, 0);
        @(negedge clk);
        u_std.mem[0][8]  = ~u_std.mem[0][8];
        u_fwft.mem[0][8] = ~u_fwft.mem[0][8];
        q[0] = q[0] | 256;
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
`endif

        cycle(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
